// File: rtl/dsp48e_cmac_ctrl.sv
// OPMODE/ALUMODE sequencer turning a DSP48E complex-multiply slice into a windowed accumulator.
// Build option: define DSP48E_CMAC_CTRL_CASCADE_EN to seed each window from PCIN instead of zero.
module dsp48e_cmac_ctrl #(
   parameter int unsigned DSP_INPUT_REGISTERS = 2,
   parameter int unsigned ACC_LEN_BITS        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    in_sync,
   input  logic [ACC_LEN_BITS-1:0] acc_len,
   output logic [6:0]              opmode,
   output logic [3:0]              alumode,
   output logic                    out_valid,
   output logic                    win_err,
   output logic                    busy
);

   localparam int unsigned DLY = (DSP_INPUT_REGISTERS < 1) ? 1 : DSP_INPUT_REGISTERS;

`ifdef DSP48E_CMAC_CTRL_CASCADE_EN
   localparam logic [6:0] OP_FIRST = 7'h15;
`else
   localparam logic [6:0] OP_FIRST = 7'h05;
`endif
   localparam logic [6:0] OP_ADD  = 7'h25;
   localparam logic [6:0] OP_HOLD = 7'h20;
   localparam logic [6:0] OP_ZERO = 7'h00;

   typedef enum logic {IDLE, ACCUM} state_t;
   typedef enum logic [1:0] {DEC_HOLD, DEC_FIRST, DEC_ADD} dec_t;

   state_t                  state_q, state_nxt;
   logic [ACC_LEN_BITS-1:0] cnt_q, cnt_nxt;
   logic [ACC_LEN_BITS-1:0] len_q, len_nxt;
   logic [ACC_LEN_BITS-1:0] len_in;
   dec_t                    dec_c;
   logic                    last_c;
   logic                    err_c;

   logic [6:0]              op_sr   [DLY];
   logic                    last_sr [DLY];
   logic [1:0]              vd_q;
   logic                    err_q;
   logic                    busy_q;

   function automatic logic [6:0] enc(input dec_t d);
      case (d)
         DEC_FIRST: enc = OP_FIRST;
         DEC_ADD:   enc = OP_ADD;
         default:   enc = OP_HOLD;
      endcase
   endfunction

   assign len_in = (acc_len == '0) ? ACC_LEN_BITS'(1) : acc_len;

   // Per-sample decision: a sync always opens a fresh window, aborting any open one.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      len_nxt   = len_q;
      dec_c     = DEC_HOLD;
      last_c    = 1'b0;
      err_c     = 1'b0;
      if (in_valid && in_sync) begin
         err_c   = (state_q == ACCUM);
         dec_c   = DEC_FIRST;
         len_nxt = len_in;
         cnt_nxt = ACC_LEN_BITS'(1);
         if (len_in == ACC_LEN_BITS'(1)) begin
            last_c    = 1'b1;
            state_nxt = IDLE;
         end else begin
            state_nxt = ACCUM;
         end
      end else if (in_valid && (state_q == ACCUM)) begin
         dec_c   = DEC_ADD;
         cnt_nxt = cnt_q + ACC_LEN_BITS'(1);
         if (cnt_nxt == len_q) begin
            last_c    = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         len_q   <= len_nxt;
      end
   end

   // Decision delay line; its final stage is the opmode register itself (zero out of reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DLY; i++) begin
            op_sr[i]   <= (i == DLY - 1) ? OP_ZERO : OP_HOLD;
            last_sr[i] <= 1'b0;
         end
         vd_q   <= '0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         op_sr[0]   <= enc(dec_c);
         last_sr[0] <= last_c;
         for (int unsigned i = 1; i < DLY; i++) begin
            op_sr[i]   <= op_sr[i-1];
            last_sr[i] <= last_sr[i-1];
         end
         vd_q   <= {vd_q[0], last_sr[DLY-1]};
         err_q  <= err_c;
         busy_q <= (state_nxt == ACCUM);
      end
   end

   assign opmode    = op_sr[DLY-1];
   assign alumode   = 4'b0000;
   assign out_valid = vd_q[1];
   assign win_err   = err_q;
   assign busy      = busy_q;

endmodule
